// File: rtl/operand_collector_4.sv
// rtl/operand_collector_4.sv - four-unit operand collector with four-bank read capture and round-robin dispatch
module operand_collector_4 (
    input  logic         clk,
    input  logic         rst,
    input  logic         Alloc_Valid,
    input  logic [31:0]  Alloc_Instr,
    input  logic         Alloc_Src1_Need,
    input  logic         Alloc_Src2_Need,
    output logic         Alloc_Ready,
    output logic [1:0]   Alloc_OCID,
    input  logic [3:0]   Bank_OCID_0,
    input  logic [3:0]   Bank_OCID_1,
    input  logic [3:0]   Bank_OCID_2,
    input  logic [3:0]   Bank_OCID_3,
    input  logic         Bank_WR_0,
    input  logic         Bank_WR_1,
    input  logic         Bank_WR_2,
    input  logic         Bank_WR_3,
    input  logic [255:0] Bank_Data_0,
    input  logic [255:0] Bank_Data_1,
    input  logic [255:0] Bank_Data_2,
    input  logic [255:0] Bank_Data_3,
    output logic         Disp_Valid,
    input  logic         Disp_Ready,
    output logic [1:0]   Disp_OCID,
    output logic [31:0]  Disp_Instr,
    output logic [255:0] Disp_Src1,
    output logic [255:0] Disp_Src2,
    output logic         Err_Stray,
    output logic         Err_Conflict
);
    typedef enum logic [1:0] {FREE = 2'd0, COLLECT = 2'd1, READY = 2'd2} unit_state_t;

    unit_state_t  st       [4];
    logic [31:0]  instr    [4];
    logic [255:0] src      [4][2];
    logic [1:0]   pend     [4];
    logic [3:0]   d_tag    [4];
    logic         d_wr     [4];
    logic [3:0]   bank_tag [4];
    logic         bank_wr  [4];
    logic [255:0] bank_data[4];
    logic [1:0]   rr_ptr;
    logic         lock;
    logic [1:0]   lock_sel;

    logic [1:0]   cap_en    [4];
    logic [255:0] cap_data  [4][2];
    logic [1:0]   pend_next [4];
    logic         stray_hit, conflict_hit;
    logic         rr_found;
    logic [1:0]   rr_sel, idx, disp_sel;
    logic         alloc_fire, disp_fire;

    assign bank_tag[0]  = Bank_OCID_0;
    assign bank_tag[1]  = Bank_OCID_1;
    assign bank_tag[2]  = Bank_OCID_2;
    assign bank_tag[3]  = Bank_OCID_3;
    assign bank_wr[0]   = Bank_WR_0;
    assign bank_wr[1]   = Bank_WR_1;
    assign bank_wr[2]   = Bank_WR_2;
    assign bank_wr[3]   = Bank_WR_3;
    assign bank_data[0] = Bank_Data_0;
    assign bank_data[1] = Bank_Data_1;
    assign bank_data[2] = Bank_Data_2;
    assign bank_data[3] = Bank_Data_3;

    // Lowest-index FREE unit, decoded from registered state only.
    always_comb begin
        Alloc_Ready = 1'b0;
        Alloc_OCID  = 2'd0;
        for (int u = 3; u >= 0; u--) begin
            if (st[u] == FREE) begin
                Alloc_Ready = 1'b1;
                Alloc_OCID  = 2'(u);
            end
        end
    end

    // Once offered, the dispatch choice is held until the handshake.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = rr_ptr;
        idx      = rr_ptr;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!rr_found && st[idx] == READY) begin
                rr_found = 1'b1;
                rr_sel   = idx;
            end
        end
        disp_sel   = lock ? lock_sel : rr_sel;
        Disp_Valid = lock | rr_found;
        Disp_OCID  = Disp_Valid ? disp_sel : 2'd0;
        Disp_Instr = Disp_Valid ? instr[disp_sel] : 32'd0;
        Disp_Src1  = Disp_Valid ? src[disp_sel][0] : 256'd0;
        Disp_Src2  = Disp_Valid ? src[disp_sel][1] : 256'd0;
    end

    assign alloc_fire = Alloc_Valid & Alloc_Ready;
    assign disp_fire  = Disp_Valid & Disp_Ready;

    // Lower bank index claims a slot first; later banks hitting it are conflicts.
    always_comb begin
        stray_hit    = 1'b0;
        conflict_hit = 1'b0;
        for (int u = 0; u < 4; u++) begin
            cap_en[u]      = 2'b00;
            cap_data[u][0] = 256'd0;
            cap_data[u][1] = 256'd0;
        end
        for (int b = 0; b < 4; b++) begin
            if (d_tag[b][3] && !d_wr[b]) begin
                if (st[d_tag[b][2:1]] != COLLECT || !pend[d_tag[b][2:1]][d_tag[b][0]])
                    stray_hit = 1'b1;
                else if (cap_en[d_tag[b][2:1]][d_tag[b][0]])
                    conflict_hit = 1'b1;
                else begin
                    cap_en[d_tag[b][2:1]][d_tag[b][0]]   = 1'b1;
                    cap_data[d_tag[b][2:1]][d_tag[b][0]] = bank_data[b];
                end
            end
        end
        for (int u = 0; u < 4; u++)
            pend_next[u] = pend[u] & ~cap_en[u];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int u = 0; u < 4; u++) begin
                st[u]     <= FREE;
                pend[u]   <= 2'b00;
                instr[u]  <= 32'd0;
                src[u][0] <= 256'd0;
                src[u][1] <= 256'd0;
            end
            for (int b = 0; b < 4; b++) begin
                d_tag[b] <= 4'd0;
                d_wr[b]  <= 1'b0;
            end
            rr_ptr       <= 2'd0;
            lock         <= 1'b0;
            lock_sel     <= 2'd0;
            Err_Stray    <= 1'b0;
            Err_Conflict <= 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                d_tag[b] <= bank_tag[b];
                d_wr[b]  <= bank_wr[b];
            end
            if (stray_hit)
                Err_Stray <= 1'b1;
            if (conflict_hit)
                Err_Conflict <= 1'b1;
            if (disp_fire) begin
                lock   <= 1'b0;
                rr_ptr <= disp_sel + 2'd1;
            end else if (Disp_Valid) begin
                lock     <= 1'b1;
                lock_sel <= disp_sel;
            end
            for (int u = 0; u < 4; u++) begin
                if (disp_fire && disp_sel == 2'(u)) begin
                    st[u] <= FREE;
                end else if (alloc_fire && Alloc_OCID == 2'(u)) begin
                    instr[u] <= Alloc_Instr;
                    pend[u]  <= {Alloc_Src2_Need, Alloc_Src1_Need};
                    st[u]    <= (Alloc_Src1_Need | Alloc_Src2_Need) ? COLLECT : READY;
                end else if (st[u] == COLLECT) begin
                    if (cap_en[u][0])
                        src[u][0] <= cap_data[u][0];
                    if (cap_en[u][1])
                        src[u][1] <= cap_data[u][1];
                    pend[u] <= pend_next[u];
                    if (pend_next[u] == 2'b00)
                        st[u] <= READY;
                end
            end
        end
    end
endmodule
